// File: rtl/seg_scan.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Double-buffered value/dots, committed only at frame boundaries; optional leading-zero blanking.
module seg_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dots,
    input  logic        blank_lz,
    output logic [3:0]  num,
    output logic        dot,
    output logic [7:0]  an,
    output logic        pend
);

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    logic [19:0] div_cnt_q, div_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [7:0]  pend_dots_q, pend_dots_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic [7:0]  disp_dots_q, disp_dots_d;
    logic        pend_q, pend_d;

    logic        tick;
    logic        frame_end;
    logic [2:0]  msd;
    logic        blank;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign frame_end = tick && (idx_q == 3'd7);

    always_comb begin
        div_cnt_d   = tick ? 20'd0 : div_cnt_q + 20'd1;
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        pend_data_d = pend_data_q;
        pend_dots_d = pend_dots_q;
        disp_data_d = disp_data_q;
        disp_dots_d = disp_dots_q;
        pend_d      = pend_q;
        // Commit reads the old pending copy, so a load on the boundary cycle lands in the next frame.
        if (frame_end && pend_q) begin
            disp_data_d = pend_data_q;
            disp_dots_d = pend_dots_q;
            pend_d      = 1'b0;
        end
        if (load) begin
            pend_data_d = data;
            pend_dots_d = dots;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= 20'd0;
            idx_q       <= 3'd0;
            pend_data_q <= 32'd0;
            pend_dots_q <= 8'd0;
            disp_data_q <= 32'd0;
            disp_dots_q <= 8'd0;
            pend_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dots_q <= pend_dots_d;
            disp_data_q <= disp_data_d;
            disp_dots_q <= disp_dots_d;
            pend_q      <= pend_d;
        end
    end

    // Highest nonzero nibble; an all-zero value reports digit 0.
    always_comb begin
        msd = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (disp_data_q[4*k +: 4] != 4'd0) begin
                msd = 3'(k);
            end
        end
    end

    assign blank = blank_lz && (idx_q > msd) && !disp_dots_q[idx_q];
    assign num   = disp_data_q[{idx_q, 2'b00} +: 4];
    assign dot   = disp_dots_q[idx_q];
    assign an    = blank ? 8'hFF : ~(8'b1 << idx_q);
    assign pend  = pend_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with SCAN_DIV=4 (32-cycle frames): stimulus pushes the
// hand-derived expected outputs per cycle, a negedge monitor pops and compares them.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dots;
    logic        blank_lz;
    logic [3:0]  num;
    logic        dot;
    logic [7:0]  an;
    logic        pend;

    seg_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dots(dots),
        .blank_lz(blank_lz), .num(num), .dot(dot), .an(an), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tt;
        logic [3:0] num;
        logic       dot;
        logic [7:0] an;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;

    // Cycles since the last reset edge, and what the display is expected to show now.
    int          t      = 0;
    logic [31:0] e_data = 32'd0;
    logic [7:0]  e_dots = 8'd0;
    logic [7:0]  e_mask = 8'd0;
    logic        e_pend = 1'b0;
    logic        bl_v   = 1'b0;

    task automatic check(input string name, input int tt, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, tt, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            check("num",  m_e.tt, {4'd0, num},  {4'd0, m_e.num});
            check("dot",  m_e.tt, {7'd0, dot},  {7'd0, m_e.dot});
            check("an",   m_e.tt, an,           m_e.an);
            check("pend", m_e.tt, {7'd0, pend}, {7'd0, m_e.pend});
        end
    end

    task automatic cyc(input logic r, input logic ld, input logic [31:0] d, input logic [7:0] dt);
        exp_t e;
        int   s;
        @(negedge clk);
        #1;
        rst      = r;
        load     = ld;
        data     = d;
        dots     = dt;
        blank_lz = bl_v;
        @(posedge clk);
        #1;
        load = 1'b0;
        if (r) t = 0;
        else   t++;
        s      = (t / 4) % 8;
        e.tt   = t;
        e.num  = e_data[s*4 +: 4];
        e.dot  = e_dots[s];
        e.an   = e_mask[s] ? 8'hFF : ~(8'b1 << s);
        e.pend = e_pend;
        sb.push_back(e);
    endtask

    task automatic run_to(input int tt);
        while (t < tt - 1) cyc(1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; data = 32'd0; dots = 8'd0; blank_lz = 1'b0;

        // Reset, then plain scan of an all-zero display.
        cyc(1'b1, 1'b0, 32'd0, 8'd0);
        cyc(1'b1, 1'b0, 32'd0, 8'd0);
        repeat (40) cyc(1'b0, 1'b0, 32'd0, 8'd0);

        // Load during slot 2; old value shown until the frame ends.
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h1234ABCD, 8'h05);
        run_to(64);
        e_data = 32'h1234ABCD; e_dots = 8'h05; e_pend = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        run_to(96);

        // Back-to-back loads, then a load on the boundary cycle itself.
        run_to(100);
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h33333333, 8'h00);
        cyc(1'b0, 1'b1, 32'h11111111, 8'h00);
        run_to(128);
        e_data = 32'h11111111; e_dots = 8'h00;
        cyc(1'b0, 1'b1, 32'h22222222, 8'h00);
        run_to(160);
        e_data = 32'h22222222; e_pend = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        run_to(170);

        // Leading-zero blanking on 0x000000A0.
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h000000A0, 8'h00);
        run_to(192);
        e_data = 32'h000000A0; e_pend = 1'b0; e_mask = 8'hFC; bl_v = 1'b1;
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        run_to(200);
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h000000A0, 8'h20);
        run_to(224);
        e_dots = 8'h20; e_mask = 8'hDC; e_pend = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        run_to(230);
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h00000000, 8'h00);
        run_to(256);
        e_data = 32'd0; e_dots = 8'd0; e_mask = 8'hFE; e_pend = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        run_to(288);
        bl_v = 1'b0; e_mask = 8'h00;

        // Reset in slot 5 with a load pending; the pending value must never appear.
        run_to(308);
        cyc(1'b0, 1'b0, 32'd0, 8'd0);
        e_pend = 1'b1;
        cyc(1'b0, 1'b1, 32'h55555555, 8'hFF);
        e_pend = 1'b0;
        cyc(1'b1, 1'b0, 32'd0, 8'd0);
        run_to(71);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scanner for an 8-digit, common-anode 7-segment display. Holds a 32-bit hex value plus 8 decimal-point flags, cycles through the digits at a programmable refresh rate, and presents one nibble and its dot per slot to the downstream hex-to-segment decoder together with an active-low digit-enable vector. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new data.

## Interface
- SCAN_DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
- DIGITS, fixed 8: not a parameter; documented for clarity.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data/dots into the pending buffer.
- data  in  32  hex value; nibble k (data[4k+3:4k]) is shown on digit k; digit 0 is rightmost.
- dots  in  8  dots[k] lights the decimal point of digit k (active-high here).
- blank_lz  in  1  level; 1 = blank leading-zero digits.
- num  out  4  nibble for the current slot, to the decoder's num input.
- dot  out  1  dot flag for the current slot, to the decoder's dot input.
- an  out  8  digit enables, active-low, at most one bit low.
- pend  out  1  1 = a loaded value is waiting for the next frame boundary.

## Operation
- Registers: div_cnt (20 bit), idx (3 bit), pend_data/pend_dots, disp_data/disp_dots, pend flag.
- div_cnt counts 0..SCAN_DIV-1 and wraps to 0. tick = (div_cnt == SCAN_DIV-1).
- On tick: idx increments, wrapping 7 -> 0. Frame boundary = tick with idx == 7.
- load = 1: pend_data <= data, pend_dots <= dots, pend <= 1. Back-to-back loads overwrite; last one wins.
- At a frame boundary with pend = 1: disp_* <= pend_*. pend clears unless load is high the same cycle.
- Simultaneous load and commit: disp takes the old pending value; pending takes the new data; pend stays 1.
- num = disp_data[4*idx +: 4]. dot = disp_dots[idx]. an = ~(8'b1 << idx).
- Leading-zero blanking, when blank_lz = 1:
  - msd = index of the highest nonzero nibble of disp_data; msd = 0 if disp_data = 0.
  - When idx > msd and disp_dots[idx] = 0, an = 8'hFF for that slot.
  - Digit 0 is never blanked. Slot timing is unchanged.
- Outputs are decoded combinationally from registers only (idx, disp_*, blank_lz); no input-to-output combinational path except blank_lz.

## Timing
- Reset values: div_cnt = 0, idx = 0, disp_* = 0, pend_* = 0, pend = 0.
- Outputs after reset: num = 0, dot = 0, an = 8'hFE, pend = 0.
- rst dominates everything; a reset mid-frame or with a pending load discards all state.
- Slot length: exactly SCAN_DIV cycles. Frame length: 8*SCAN_DIV cycles.
- idx changes on the edge after tick; num, dot and an change in that same cycle.
- load sampled at edge t: pend = 1 visible after edge t.
- Commit: new disp_* visible on the first cycle of the following frame (idx = 0), the same cycle pend falls.
- Worst-case load-to-display latency: 8*SCAN_DIV cycles.
- blank_lz changes take effect immediately on the current slot; no glitch requirement.

## Test plan
- Reset and scan (SCAN_DIV=4): hold rst 2 cycles, then run 40 cycles -> an steps FE, FD, FB, ... 7F, FE, each for exactly 4 cycles; num = 0 throughout; pend = 0.
- Load and commit: load data=32'h1234ABCD, dots=8'h05 at idx = 2 -> pend = 1 next cycle; old value (0) shown until the frame end. From the next idx = 0: digits 0..7 show D, C, B, A, 4, 3, 2, 1; dot = 1 on digits 0 and 2; pend = 0.
- Boundary collision: pend = 1 holding 32'h11111111; pulse load with 32'h22222222 on the frame-boundary cycle -> next frame shows 1s, pend stays 1, the following frame shows 2s, then pend = 0.
- Leading-zero blank: disp = 32'h0000_00A0, blank_lz = 1, dots = 0 -> an = FF in slots 2..7; slots 0/1 show 0/A. Set dots[5] = 1 -> slot 5 shows num = 0, dot = 1. With disp = 0: only digit 0 lit.
- Reset mid-operation: assert rst at idx = 5 with pend = 1 -> next cycle idx = 0, an = FE, num = 0, pend = 0, and the pending value is never displayed.
